inst_encoder: RTL and testbench



---
 rtl/inst_encoder_if.sv | 38 +++
 rtl/inst_encoder.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Request/response bus between the program loader and the instruction encoder.
// master: loader side (drives requests, start, out_ready); slave: encoder side.
interface inst_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_class, in_op,
    output in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst,
    input  out_addr, err, err_code, count
  );

  modport slave (
    input  start, in_valid, in_class, in_op,
    input  in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst,
    output out_addr, err, err_code, count
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I(M) field-to-word encoder, two-stage valid/ready pipeline feeding IMEM fill.
// Ports: clk, rst (sync, active-high), bus (inst_encoder_if.slave). Option: ENCODER_MULDIV_EN.
module inst_encoder #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic clk,
  input logic rst,
  inst_encoder_if.slave bus
);

  localparam logic [3:0] C_R     = 4'd0;
  localparam logic [3:0] C_I     = 4'd1;
  localparam logic [3:0] C_LOAD  = 4'd2;
  localparam logic [3:0] C_STORE = 4'd3;
  localparam logic [3:0] C_BR    = 4'd4;
  localparam logic [3:0] C_JAL   = 4'd5;
  localparam logic [3:0] C_JALR  = 4'd6;
  localparam logic [3:0] C_LUI   = 4'd7;
  localparam logic [3:0] C_AUIPC = 4'd8;
  localparam logic [3:0] C_ECALL = 4'd9;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_MUL    = 4'd10;
  localparam logic [3:0] ALU_MULH   = 4'd11;
  localparam logic [3:0] ALU_MULHSU = 4'd12;
  localparam logic [3:0] ALU_MULHU  = 4'd13;
  localparam logic [3:0] ALU_DIV    = 4'd14;
  localparam logic [3:0] ALU_REM    = 4'd15;

  localparam logic [2:0] BRU_NOP  = 3'd0;
  localparam logic [2:0] BRU_BEQ  = 3'd1;
  localparam logic [2:0] BRU_BNE  = 3'd2;
  localparam logic [2:0] BRU_BLT  = 3'd3;
  localparam logic [2:0] BRU_BGE  = 3'd4;
  localparam logic [2:0] BRU_BLTU = 3'd5;
  localparam logic [2:0] BRU_BGEU = 3'd6;

  localparam logic [2:0] LB_OPERATION  = 3'd0;
  localparam logic [2:0] LH_OPERATION  = 3'd1;
  localparam logic [2:0] LW_OPERATION  = 3'd2;
  localparam logic [2:0] LBU_OPERATION = 3'd3;
  localparam logic [2:0] LHU_OPERATION = 3'd4;
  localparam logic [2:0] SB_OPERATION  = 3'd5;
  localparam logic [2:0] SH_OPERATION  = 3'd6;
  localparam logic [2:0] SW_OPERATION  = 3'd7;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [1:0] E_ILL = 2'd0;
  localparam logic [1:0] E_RNG = 2'd1;
  localparam logic [1:0] E_MIS = 2'd2;

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;
  localparam logic [ADDR_W:0]   C_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic              s1_valid;
  logic [3:0]        s1_cls;
  logic [3:0]        s1_op;
  logic [4:0]        s1_rd;
  logic [4:0]        s1_rs1;
  logic [4:0]        s1_rs2;
  logic [31:0]       s1_imm;

  logic              s2_valid;
  logic [31:0]       s2_inst;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [1:0]        code_q;

  logic        fit12, fit13, fit21, sh_ok;
  logic        alu_ok, alu_m, alu_sh;
  logic [2:0]  af3;
  logic [6:0]  af7;
  logic        b_ok, l_ok, s_ok;
  logic [2:0]  bf3, lf3, sf3;
  logic        ill, mis, rng;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic [1:0]  enc_code;
  logic        drain, s1_adv, err_now;

  assign fit12 = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
  assign fit13 = (&s1_imm[31:12]) | ~(|s1_imm[31:12]);
  assign fit21 = (&s1_imm[31:20]) | ~(|s1_imm[31:20]);
  assign sh_ok = ~(|s1_imm[31:5]);

  always_comb begin
    alu_ok = 1'b1;
    alu_m  = 1'b0;
    alu_sh = 1'b0;
    af3    = 3'd0;
    af7    = 7'h00;
    unique case (s1_op)
      ALU_ADD:  af3 = 3'd0;
      ALU_SUB: begin
        af3 = 3'd0;
        af7 = 7'h20;
      end
      ALU_SLL: begin
        af3    = 3'd1;
        alu_sh = 1'b1;
      end
      ALU_SLT:  af3 = 3'd2;
      ALU_SLTU: af3 = 3'd3;
      ALU_XOR:  af3 = 3'd4;
      ALU_SRL: begin
        af3    = 3'd5;
        alu_sh = 1'b1;
      end
      ALU_SRA: begin
        af3    = 3'd5;
        af7    = 7'h20;
        alu_sh = 1'b1;
      end
      ALU_OR:   af3 = 3'd6;
      ALU_AND:  af3 = 3'd7;
`ifdef ENCODER_MULDIV_EN
      ALU_MUL: begin
        af3 = 3'd0; af7 = 7'h01; alu_m = 1'b1;
      end
      ALU_MULH: begin
        af3 = 3'd1; af7 = 7'h01; alu_m = 1'b1;
      end
      ALU_MULHSU: begin
        af3 = 3'd2; af7 = 7'h01; alu_m = 1'b1;
      end
      ALU_MULHU: begin
        af3 = 3'd3; af7 = 7'h01; alu_m = 1'b1;
      end
      ALU_DIV: begin
        af3 = 3'd4; af7 = 7'h01; alu_m = 1'b1;
      end
      ALU_REM: begin
        af3 = 3'd6; af7 = 7'h01; alu_m = 1'b1;
      end
`else
      ALU_MUL, ALU_MULH, ALU_MULHSU,
      ALU_MULHU, ALU_DIV, ALU_REM:
        alu_ok = 1'b0;
`endif
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    b_ok = 1'b1;
    bf3  = 3'd0;
    unique case (s1_op[2:0])
      BRU_BEQ:  bf3 = 3'd0;
      BRU_BNE:  bf3 = 3'd1;
      BRU_BLT:  bf3 = 3'd4;
      BRU_BGE:  bf3 = 3'd5;
      BRU_BLTU: bf3 = 3'd6;
      BRU_BGEU: bf3 = 3'd7;
      BRU_NOP:  b_ok = 1'b0;
      default:  b_ok = 1'b0;
    endcase
  end

  always_comb begin
    l_ok = 1'b0;
    s_ok = 1'b0;
    lf3  = 3'd0;
    sf3  = 3'd0;
    unique case (s1_op[2:0])
      LB_OPERATION:  begin l_ok = 1'b1; lf3 = 3'd0; end
      LH_OPERATION:  begin l_ok = 1'b1; lf3 = 3'd1; end
      LW_OPERATION:  begin l_ok = 1'b1; lf3 = 3'd2; end
      LBU_OPERATION: begin l_ok = 1'b1; lf3 = 3'd4; end
      LHU_OPERATION: begin l_ok = 1'b1; lf3 = 3'd5; end
      SB_OPERATION:  begin s_ok = 1'b1; sf3 = 3'd0; end
      SH_OPERATION:  begin s_ok = 1'b1; sf3 = 3'd1; end
      SW_OPERATION:  begin s_ok = 1'b1; sf3 = 3'd2; end
      default: ;
    endcase
  end

  always_comb begin
    ill      = 1'b0;
    mis      = 1'b0;
    rng      = 1'b0;
    enc_inst = 32'h0;
    unique case (1'b1)
      (s1_cls == C_R): begin
        ill      = !alu_ok;
        enc_inst = {af7, s1_rs2, s1_rs1, af3, s1_rd, OP_R};
      end
      (s1_cls == C_I): begin
        // no immediate form of SUB or of any M-extension op
        ill = !alu_ok || alu_m || (s1_op == ALU_SUB);
        if (alu_sh) begin
          rng      = !sh_ok;
          enc_inst = {af7, s1_imm[4:0], s1_rs1, af3, s1_rd, OP_I};
        end else begin
          rng      = !fit12;
          enc_inst = {s1_imm[11:0], s1_rs1, af3, s1_rd, OP_I};
        end
      end
      (s1_cls == C_LOAD): begin
        ill      = !l_ok;
        rng      = !fit12;
        enc_inst = {s1_imm[11:0], s1_rs1, lf3, s1_rd, OP_LOAD};
      end
      (s1_cls == C_STORE): begin
        ill      = !s_ok;
        rng      = !fit12;
        enc_inst = {s1_imm[11:5], s1_rs2, s1_rs1, sf3,
                    s1_imm[4:0], OP_STORE};
      end
      (s1_cls == C_BR): begin
        ill      = !b_ok;
        mis      = s1_imm[0];
        rng      = !fit13;
        enc_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1,
                    bf3, s1_imm[4:1], s1_imm[11], OP_BR};
      end
      (s1_cls == C_JAL): begin
        mis      = s1_imm[0];
        rng      = !fit21;
        enc_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                    s1_imm[19:12], s1_rd, OP_JAL};
      end
      (s1_cls == C_JALR): begin
        rng      = !fit12;
        enc_inst = {s1_imm[11:0], s1_rs1, 3'd0, s1_rd, OP_JALR};
      end
      (s1_cls == C_LUI): begin
        rng      = |s1_imm[11:0];
        enc_inst = {s1_imm[31:12], s1_rd, OP_LUI};
      end
      (s1_cls == C_AUIPC): begin
        rng      = |s1_imm[11:0];
        enc_inst = {s1_imm[31:12], s1_rd, OP_AUIPC};
      end
      (s1_cls == C_ECALL): enc_inst = 32'h0000_0073;
      default: ill = 1'b1;
    endcase
  end

  assign enc_err  = ill | mis | rng;
  assign enc_code = ill ? E_ILL : (mis ? E_MIS : E_RNG);

  // an erroring S1 entry never waits on S2: it is simply dropped
  assign drain   = s2_valid && bus.out_ready;
  assign s1_adv  = s1_valid && (!s2_valid || drain || enc_err);
  assign err_now = !rst && s1_adv && enc_err;

  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_inst  = s2_inst;
  assign bus.out_addr  = addr_q;
  assign bus.count     = cnt_q;
  assign bus.err       = err_now;
  assign bus.err_code  = err_now ? enc_code : code_q;

  always_ff @(posedge clk) begin
    if (bus.in_ready && bus.in_valid) begin
      s1_cls <= bus.in_class;
      s1_op  <= bus.in_op;
      s1_rd  <= bus.in_rd;
      s1_rs1 <= bus.in_rs1;
      s1_rs2 <= bus.in_rs2;
      s1_imm <= bus.in_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_inst  <= 32'h0;
      addr_q   <= BASE_ADDR;
      cnt_q    <= '0;
      code_q   <= E_ILL;
    end else begin
      if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (s1_adv && !enc_err) begin
        s2_valid <= 1'b1;
        s2_inst  <= enc_inst;
      end else if (drain) begin
        s2_valid <= 1'b0;
      end
      if (err_now)
        code_q <= enc_code;
      // start wins: a word drained now keeps its old address
      if (bus.start) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
      end else if (drain) begin
        addr_q <= addr_q + A_ONE;
        if (cnt_q != C_MAX)
          cnt_q <= cnt_q + C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: two instances (base 0 and base 4094)
// share one stimulus stream; each step checks outputs with immediate asserts.
module tb_inst_encoder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  inst_encoder_if #(.ADDR_W(12)) bus0 ();
  inst_encoder_if #(.ADDR_W(12)) bus1 ();

  inst_encoder #(.ADDR_W(12), .BASE_ADDR(12'd0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  inst_encoder #(.ADDR_W(12), .BASE_ADDR(12'd4094)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus1.start     = bus0.start;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_class  = bus0.in_class;
  assign bus1.in_op     = bus0.in_op;
  assign bus1.in_rd     = bus0.in_rd;
  assign bus1.in_rs1    = bus0.in_rs1;
  assign bus1.in_rs2    = bus0.in_rs2;
  assign bus1.in_imm    = bus0.in_imm;
  assign bus1.out_ready = bus0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] c, input logic [3:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    bus0.in_valid = 1'b1;
    bus0.in_class = c;
    bus0.in_op    = op;
    bus0.in_rd    = rd;
    bus0.in_rs1   = rs1;
    bus0.in_rs2   = rs2;
    bus0.in_imm   = imm;
    #1;
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0;
    bus0.in_class = 4'd0;
    bus0.in_op    = 4'd0;
    bus0.in_rd    = 5'd0;
    bus0.in_rs1   = 5'd0;
    bus0.in_rs2   = 5'd0;
    bus0.in_imm   = 32'd0;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus0.out_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_inst", bus0.out_inst, 0);
    chk("rst_addr", bus0.out_addr, 0);
    chk("rst_addr_b", bus1.out_addr, 4094);
    chk("rst_count", bus0.count, 0);
    chk("rst_err", bus0.err, 0);
    chk("rst_err_code", bus0.err_code, 0);

    // addi / add / sub back to back
    req(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    req(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req(4'd0, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("addi_valid", bus0.out_valid, 1);
    chk("addi_inst", bus0.out_inst, 32'h0050_0093);
    chk("addi_addr", bus0.out_addr, 0);
    chk("addi_addr_b", bus1.out_addr, 4094);
    tick();
    idle();
    chk("add_inst", bus0.out_inst, 32'h0020_81B3);
    chk("add_addr", bus0.out_addr, 1);
    chk("add_addr_b", bus1.out_addr, 4095);
    tick();
    chk("sub_inst", bus0.out_inst, 32'h4020_81B3);
    chk("sub_addr", bus0.out_addr, 2);
    chk("sub_addr_b_wrap", bus1.out_addr, 0);
    tick();
    chk("t1_idle_valid", bus0.out_valid, 0);
    chk("t1_count", bus0.count, 3);

    // sw / beq / lui
    req(4'd3, 4'd7, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    req(4'd4, 4'd1, 5'd0, 5'd1, 5'd2, -32'sd4);
    tick();
    req(4'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    chk("sw_inst", bus0.out_inst, 32'h0020_A423);
    chk("sw_addr", bus0.out_addr, 3);
    tick();
    idle();
    chk("beq_inst", bus0.out_inst, 32'hFE20_8EE3);
    tick();
    chk("lui_inst", bus0.out_inst, 32'h1234_52B7);
    chk("lui_addr", bus0.out_addr, 5);
    tick();
    chk("t2_count", bus0.count, 6);

    // range, misaligned, illegal-class errors
    req(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    req(4'd4, 4'd1, 5'd0, 5'd1, 5'd2, 32'd7);
    chk("e1_err", bus0.err, 1);
    chk("e1_code", bus0.err_code, 1);
    tick();
    req(4'd12, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("e2_err", bus0.err, 1);
    chk("e2_code", bus0.err_code, 2);
    tick();
    idle();
    chk("e3_err", bus0.err, 1);
    chk("e3_code", bus0.err_code, 0);
    chk("e3_valid", bus0.out_valid, 0);
    tick();
    chk("e4_err", bus0.err, 0);
    chk("e4_valid", bus0.out_valid, 0);
    chk("e4_addr", bus0.out_addr, 6);
    chk("e4_count", bus0.count, 6);

    // backpressure: 5 stalled cycles, 3 requests offered
    bus0.out_ready = 1'b0;
    req(4'd0, 4'd5, 5'd4, 5'd5, 5'd6, 32'd0);
    tick();
    req(4'd1, 4'd7, 5'd7, 5'd8, 5'd0, 32'd3);
    chk("st_rdy1", bus0.in_ready, 1);
    tick();
    req(4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("st_rdy2", bus0.in_ready, 0);
    chk("st_valid", bus0.out_valid, 1);
    chk("st_inst2", bus0.out_inst, 32'h0062_C233);
    tick();
    chk("st_rdy3", bus0.in_ready, 0);
    chk("st_inst3", bus0.out_inst, 32'h0062_C233);
    tick();
    chk("st_rdy4", bus0.in_ready, 0);
    chk("st_inst4", bus0.out_inst, 32'h0062_C233);
    tick();
    bus0.out_ready = 1'b1;
    #1;
    chk("rl_xor_inst", bus0.out_inst, 32'h0062_C233);
    chk("rl_xor_addr", bus0.out_addr, 6);
    chk("rl_rdy", bus0.in_ready, 1);
    tick();
    idle();
    chk("rl_srai_inst", bus0.out_inst, 32'h4034_5393);
    chk("rl_srai_addr", bus0.out_addr, 7);
    tick();
    chk("rl_jal_inst", bus0.out_inst, 32'h0010_00EF);
    chk("rl_jal_addr", bus0.out_addr, 8);
    tick();
    chk("rl_idle", bus0.out_valid, 0);
    chk("rl_count", bus0.count, 9);

    // start coincident with a handshake
    req(4'd2, 4'd2, 5'd10, 5'd2, 5'd0, -32'sd4);
    tick();
    req(4'd4, 4'd2, 5'd0, 5'd3, 5'd4, 32'd8);
    tick();
    idle();
    bus0.start = 1'b1;
    #1;
    chk("sa_lw_inst", bus0.out_inst, 32'hFFC1_2503);
    chk("sa_lw_addr", bus0.out_addr, 9);
    chk("sa_lw_addr_b", bus1.out_addr, 7);
    tick();
    bus0.start = 1'b0;
    #1;
    chk("sa_bne_inst", bus0.out_inst, 32'h0041_9463);
    chk("sa_bne_addr", bus0.out_addr, 0);
    chk("sa_bne_addr_b", bus1.out_addr, 4094);
    chk("sa_count0", bus0.count, 0);
    tick();
    chk("sa_count1", bus0.count, 1);
    chk("sa_addr1", bus0.out_addr, 1);

    // illegal ops and misaligned-over-range priority
    req(4'd2, 4'd7, 5'd1, 5'd1, 5'd0, 32'd0);
    tick();
    req(4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("il_ld_err", bus0.err, 1);
    chk("il_ld_code", bus0.err_code, 0);
    tick();
    req(4'd4, 4'd1, 5'd0, 5'd1, 5'd2, 32'd8191);
    chk("il_br_err", bus0.err, 1);
    chk("il_br_code", bus0.err_code, 0);
    tick();
    idle();
    chk("pr_err", bus0.err, 1);
    chk("pr_code", bus0.err_code, 2);
    tick();
    chk("pr_hold_err", bus0.err, 0);
    chk("pr_hold_code", bus0.err_code, 2);

    // U-type low bits, then mul
    req(4'd7, 4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5123);
    tick();
    req(4'd0, 4'd10, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("lui_rng_err", bus0.err, 1);
    chk("lui_rng_code", bus0.err_code, 1);
    tick();
    idle();
`ifdef ENCODER_MULDIV_EN
    chk("mul_err", bus0.err, 0);
    chk("mul_valid", bus0.out_valid, 1);
    chk("mul_inst", bus0.out_inst, 32'h0220_81B3);
    chk("mul_addr", bus0.out_addr, 1);
    tick();
    chk("mul_hold_code", bus0.err_code, 1);
    chk("mul_count", bus0.count, 2);
`else
    chk("mul_err", bus0.err, 1);
    chk("mul_code", bus0.err_code, 0);
    chk("mul_valid", bus0.out_valid, 0);
    tick();
    chk("mul_hold_code", bus0.err_code, 0);
    chk("mul_count", bus0.count, 1);
`endif
    chk("mul_err_done", bus0.err, 0);

    // reset mid-stream with a valid word in S2 and an error in S1
    bus0.out_ready = 1'b0;
    req(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    req(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("mr_no_err", bus0.err, 0);
    tick();
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    #1;
    chk("mr_valid", bus0.out_valid, 0);
    chk("mr_rdy", bus0.in_ready, 1);
    chk("mr_err", bus0.err, 0);
    chk("mr_code", bus0.err_code, 0);
    chk("mr_count", bus0.count, 0);
    chk("mr_addr", bus0.out_addr, 0);
    chk("mr_addr_b", bus1.out_addr, 4094);
    chk("mr_inst", bus0.out_inst, 0);
    tick();
    chk("mr_still_empty", bus0.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
